// File: rtl/fm_ctrl_pkg.sv
// Shared types and constants for the FM output-scaling controller.
package fm_ctrl_pkg;

  localparam int unsigned SHIFT_W   = 4;
  localparam logic [5:0]  PEAK_NONE = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DECIDE
  } state_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/msb_index.sv
// Priority encoder: index of the highest set bit of an unsigned word, plus zero flag.
module msb_index #(
  parameter int unsigned W = 48
) (
  input  logic [W-1:0] val,
  output logic [5:0]   idx,
  output logic         zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx  = '0;
    zero = (val == '0);
    for (int unsigned i = 0; i < W; i++) begin
      if (val[i]) idx = 6'(i);
    end
  end

endmodule

// File: rtl/fm_shift_ctrl.sv
// Closed-loop shift scheduler for the FM demodulator output-scaling stage:
// settle, measure the window peak of |diff_in|, then step shift_num toward
// the target bit band.
module fm_shift_ctrl
  import fm_ctrl_pkg::*;
#(
  parameter int unsigned DIFF_W     = 48,
  parameter int unsigned TOP_BASE   = 25,
  parameter int unsigned SHIFT_INIT = 5,
  parameter int unsigned SHIFT_MIN  = 0,
  parameter int unsigned SHIFT_MAX  = 12,
  parameter int unsigned SETTLE_N   = 64,
  parameter int unsigned RESETTLE_N = 4,
  parameter int unsigned WIN_N      = 1024,
  parameter int unsigned LOCK_N     = 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     en,
  input  logic signed [DIFF_W-1:0] diff_in,
  input  logic                     diff_valid,
  output logic                     demod_en,
  output logic [SHIFT_W-1:0]       shift_num,
  output logic                     locked,
  output logic [5:0]               peak_msb,
  output logic                     win_done
);

  localparam int unsigned CNT_MAX = umax(umax(SETTLE_N, RESETTLE_N), WIN_N);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCK_N + 1);

  localparam logic [SHIFT_W-1:0] S_INIT   = SHIFT_W'(SHIFT_INIT);
  localparam logic [SHIFT_W-1:0] S_MIN    = SHIFT_W'(SHIFT_MIN);
  localparam logic [SHIFT_W-1:0] S_MAX    = SHIFT_W'(SHIFT_MAX);
  localparam logic [LOCK_W-1:0]  LOCK_TOP = LOCK_W'(LOCK_N);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [DIFF_W-1:0]  MOST_NEG = {1'b1, {(DIFF_W-1){1'b0}}};
  localparam logic [DIFF_W-1:0]  MAG_SAT  = {1'b0, {(DIFF_W-1){1'b1}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIFF_W-1:0]   peak_q, peak_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic                locked_q, locked_d;
  logic [5:0]          pmsb_q, pmsb_d;

  logic [DIFF_W-1:0]   raw;
  logic [DIFF_W-1:0]   mag;
  logic [5:0]          p_idx;
  logic                p_zero;
  logic [SHIFT_W-1:0]  new_shift;
  logic [LOCK_W-1:0]   lock_inc;
  int                  top_i;
  int                  p_i;

  msb_index #(.W(DIFF_W)) u_msb (
    .val  (peak_q),
    .idx  (p_idx),
    .zero (p_zero)
  );

  // Magnitude of the incoming sample; the most-negative code saturates.
  always_comb begin
    raw = diff_in;
    mag = raw;
    if (raw[DIFF_W-1]) begin
      if (raw == MOST_NEG) mag = MAG_SAT;
      else                 mag = (~raw) + 1'b1;
    end
  end

  // Shift decision from the registered window peak.
  always_comb begin
    top_i     = int'(TOP_BASE) - int'(shift_q);
    p_i       = int'(p_idx);
    new_shift = shift_q;
    if (!p_zero) begin
      if (p_i >= top_i) begin
        if (shift_q < S_MAX) new_shift = shift_q + 1'b1;
      end else if (p_i < top_i - 2) begin
        if (shift_q > S_MIN) new_shift = shift_q - 1'b1;
      end
    end
    lock_inc = (lock_q == LOCK_TOP) ? lock_q : lock_q + 1'b1;
  end

  // Next-state and datapath update; en low overrides every active state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    peak_d   = peak_q;
    shift_d  = shift_q;
    lock_d   = lock_q;
    locked_d = locked_q;
    pmsb_d   = pmsb_q;

    if (!en && state_q != IDLE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      peak_d   = '0;
      lock_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            shift_d = S_INIT;
            cnt_d   = CNT_W'(SETTLE_N);
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (diff_valid) begin
            if (cnt_q == CNT_ONE) begin
              peak_d  = '0;
              cnt_d   = CNT_W'(WIN_N);
              state_d = MEASURE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        MEASURE: begin
          if (diff_valid) begin
            if (mag > peak_q) peak_d = mag;
            if (cnt_q == CNT_ONE) begin
              cnt_d   = '0;
              state_d = DECIDE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        DECIDE: begin
          // The peak clears here so every window measures independently.
          pmsb_d = p_zero ? PEAK_NONE : p_idx;
          peak_d = '0;
          if (p_zero) begin
            cnt_d   = CNT_W'(WIN_N);
            state_d = MEASURE;
          end else if (new_shift != shift_q) begin
            shift_d  = new_shift;
            lock_d   = '0;
            locked_d = 1'b0;
            cnt_d    = CNT_W'(RESETTLE_N);
            state_d  = SETTLE;
          end else begin
            lock_d   = lock_inc;
            locked_d = (lock_inc == LOCK_TOP);
            cnt_d    = CNT_W'(WIN_N);
            state_d  = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      peak_q   <= '0;
      shift_q  <= S_INIT;
      lock_q   <= '0;
      locked_q <= 1'b0;
      pmsb_q   <= PEAK_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      peak_q   <= peak_d;
      shift_q  <= shift_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
      pmsb_q   <= pmsb_d;
    end
  end

  assign demod_en  = (state_q != IDLE);
  assign win_done  = (state_q == DECIDE);
  assign shift_num = shift_q;
  assign locked    = locked_q;
  assign peak_msb  = pmsb_q;

endmodule

// File: tb/tb_fm_shift_ctrl.sv
// Window-level directed bench for fm_shift_ctrl.
module tb_fm_shift_ctrl;

  logic               sys_clk;
  logic               sys_rst;
  logic               en;
  logic signed [47:0] diff_in;
  logic               diff_valid;
  logic               demod_en;
  logic [3:0]         shift_num;
  logic               locked;
  logic [5:0]         peak_msb;
  logic               win_done;

  int checks   = 0;
  int failures = 0;

  fm_shift_ctrl #(
    .DIFF_W     (48),
    .TOP_BASE   (25),
    .SHIFT_INIT (5),
    .SHIFT_MIN  (0),
    .SHIFT_MAX  (12),
    .SETTLE_N   (64),
    .RESETTLE_N (4),
    .WIN_N      (1024),
    .LOCK_N     (3)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .diff_in    (diff_in),
    .diff_valid (diff_valid),
    .demod_en   (demod_en),
    .shift_num  (shift_num),
    .locked     (locked),
    .peak_msb   (peak_msb),
    .win_done   (win_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic signed [47:0] amp;
    bit                 alt;
    int                 pre_n;
    logic signed [47:0] pre_amp;
    int                 exp_n;
    logic [3:0]         exp_shift;
    logic               exp_locked;
    logic [5:0]         exp_pmsb;
  } win_t;

  win_t wins[$];

  localparam logic signed [47:0] P30  = 48'sd1 <<< 30;
  localparam logic signed [47:0] P22  = 48'sd1 <<< 22;
  localparam logic signed [47:0] P19  = 48'sd1 <<< 19;
  localparam logic signed [47:0] P18  = 48'sd1 <<< 18;
  localparam logic signed [47:0] P10  = 48'sd1 <<< 10;
  localparam logic signed [47:0] P3   = 48'sd8;
  localparam logic signed [47:0] HUGE = 48'sd1 <<< 40;
  localparam logic signed [47:0] MNEG = 48'sh8000_0000_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic signed [47:0] amp, input bit alt, input int pre_n,
                     input logic signed [47:0] pre_amp, input int exp_n,
                     input int sh, input bit lk, input int pm);
    win_t w;
    w.amp = amp; w.alt = alt; w.pre_n = pre_n; w.pre_amp = pre_amp;
    w.exp_n = exp_n; w.exp_shift = 4'(sh); w.exp_locked = lk; w.exp_pmsb = 6'(pm);
    wins.push_back(w);
  endtask

  // Streams one sample per cycle until DECIDE is seen, then offers a sample
  // during DECIDE (must be dropped) and steps one cycle past the decision.
  task automatic feed(input win_t w, input int idx, output int n);
    logic signed [47:0] v;
    bit done;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (win_done) begin
        done = 1'b1;
        break;
      end
      v = (n < w.pre_n) ? w.pre_amp : w.amp;
      if (w.alt && n[0]) v = -v;
      diff_valid = 1'b1;
      diff_in    = v;
      n++;
      @(posedge sys_clk); #1;
    end
    if (!done) begin
      failures++;
      checks++;
      $display("FAIL w%0d_timeout got=%0d want=%0d", idx, n, w.exp_n);
    end
    diff_valid = 1'b1;
    diff_in    = HUGE;
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wd_seen;
    int de_seen;

    add(P19, 1, 64, P30, 1088, 5, 0, 19);
    add(48'sd0, 0, 0, 48'sd0, 1024, 5, 0, 63);
    add(48'sd0, 0, 0, 48'sd0, 1024, 5, 0, 63);
    add(P18, 1, 0, 48'sd0, 1024, 5, 0, 18);
    add(P19 + 48'sd5, 1, 0, 48'sd0, 1024, 5, 1, 19);
    add(P22, 1, 0, 48'sd0, 1024, 6, 0, 22);
    for (int s = 7; s <= 12; s++) add(P22, 1, 0, 48'sd0, 1028, s, 0, 22);
    add(P22, 1, 0, 48'sd0, 1028, 12, 0, 22);
    add(P22, 1, 0, 48'sd0, 1024, 12, 0, 22);
    add(P22, 1, 0, 48'sd0, 1024, 12, 1, 22);
    add(P3, 1, 64, P30, 1088, 4, 0, 3);
    for (int s = 3; s >= 0; s--) add(P3, 1, 0, 48'sd0, 1028, s, 0, 3);
    add(P3, 1, 0, 48'sd0, 1028, 0, 0, 3);
    add(P3, 1, 0, 48'sd0, 1024, 0, 0, 3);
    add(P3, 1, 0, 48'sd0, 1024, 0, 1, 3);
    add(MNEG, 0, 0, 48'sd0, 1024, 1, 0, 46);
    for (int s = 2; s <= 12; s++) add(MNEG, 0, 0, 48'sd0, 1028, s, 0, 46);
    add(MNEG, 0, 0, 48'sd0, 1028, 12, 0, 46);

    sys_rst = 1'b1; en = 1'b1; diff_valid = 1'b0; diff_in = '0;
    @(posedge sys_clk); #1;
    for (int k = 0; k < 6; k++) begin
      diff_valid = k[0];
      diff_in    = P30;
      @(posedge sys_clk); #1;
      chk($sformatf("rst%0d_demod_en", k), 64'(demod_en), 64'd0);
      chk($sformatf("rst%0d_shift", k), 64'(shift_num), 64'd5);
      chk($sformatf("rst%0d_locked", k), 64'(locked), 64'd0);
      chk($sformatf("rst%0d_pmsb", k), 64'(peak_msb), 64'd63);
    end
    sys_rst = 1'b0; en = 1'b0; diff_valid = 1'b0;
    repeat (2) begin @(posedge sys_clk); #1; end
    chk("idle_demod_en", 64'(demod_en), 64'd0);
    chk("idle_win_done", 64'(win_done), 64'd0);
    en = 1'b1;
    @(posedge sys_clk); #1;
    chk("start_demod_en", 64'(demod_en), 64'd1);
    chk("start_shift", 64'(shift_num), 64'd5);

    for (int i = 0; i < wins.size(); i++) begin
      if (i == 15) begin
        for (int k = 0; k < 500; k++) begin
          diff_valid = 1'b1; diff_in = P10;
          @(posedge sys_clk); #1;
        end
        en = 1'b0;
        @(posedge sys_clk); #1;
        chk("dis_demod_en", 64'(demod_en), 64'd0);
        chk("dis_locked", 64'(locked), 64'd0);
        chk("dis_shift", 64'(shift_num), 64'd12);
        chk("dis_pmsb", 64'(peak_msb), 64'd22);
        wd_seen = 0; de_seen = 0;
        for (int k = 0; k < 10; k++) begin
          @(posedge sys_clk); #1;
          wd_seen += int'(win_done);
          de_seen += int'(demod_en);
        end
        chk("dis_idle_win_done", 64'(wd_seen), 64'd0);
        chk("dis_idle_demod_en", 64'(de_seen), 64'd0);
        en = 1'b1; diff_valid = 1'b0;
        @(posedge sys_clk); #1;
        chk("reen_shift", 64'(shift_num), 64'd5);
        chk("reen_demod_en", 64'(demod_en), 64'd1);
        chk("reen_locked", 64'(locked), 64'd0);
      end
      feed(wins[i], i, n);
      chk($sformatf("w%0d_samples", i), 64'(n), 64'(wins[i].exp_n));
      chk($sformatf("w%0d_shift", i), 64'(shift_num), 64'(wins[i].exp_shift));
      chk($sformatf("w%0d_locked", i), 64'(locked), 64'(wins[i].exp_locked));
      chk($sformatf("w%0d_pmsb", i), 64'(peak_msb), 64'(wins[i].exp_pmsb));
      chk($sformatf("w%0d_win_done_pulse", i), 64'(win_done), 64'd0);
      chk($sformatf("w%0d_demod_en", i), 64'(demod_en), 64'd1);
    end

    for (int k = 0; k < 300; k++) begin
      diff_valid = 1'b1; diff_in = MNEG;
      @(posedge sys_clk); #1;
    end
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("midrst_demod_en", 64'(demod_en), 64'd0);
    chk("midrst_shift", 64'(shift_num), 64'd5);
    chk("midrst_locked", 64'(locked), 64'd0);
    chk("midrst_pmsb", 64'(peak_msb), 64'd63);
    chk("midrst_win_done", 64'(win_done), 64'd0);
    sys_rst = 1'b0; en = 1'b0; diff_valid = 1'b0;
    @(posedge sys_clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
